wb_packet_bridge: RTL and testbench
===================================

Name: wb_packet_bridge

Overview:
Upstream command stage for wishbone_master. Parses a byte stream (from the USB/UART byte link) into read/write packets and drives the master's packet interface: transfer_address, payload_in, payload_length, start_read/start_write. Waits for completion, then returns a status byte and, for reads, the payload_out bytes on an outbound byte stream.

Parameters:
ADDRESS_WIDTH, 16, bus address width; frame carries 2 address bytes, MSB first; bits above ADDRESS_WIDTH dropped.
DATA_WIDTH, 8, byte width of streams and of one payload element.
MAX_PAYLOAD, 8, maximum bytes per transfer; must be a power of two, 2..64.
LEN_N, 3, payload_length width = log2(MAX_PAYLOAD).
RX_TIMEOUT, 1024, idle cycles inside a partial frame before it is discarded.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
rx_data_i  in  8  inbound byte
rx_valid_i  in  1  inbound byte valid
rx_ready_o  out  1  bridge accepts byte when rx_valid_i & rx_ready_o
tx_data_o  out  8  outbound byte
tx_valid_o  out  1  outbound byte valid
tx_ready_i  in  1  sink accepts byte when tx_valid_o & tx_ready_i
transfer_address  out  ADDRESS_WIDTH  to master
payload_in  out  MAX_PAYLOAD*8  write data; byte k at [8k+7:8k]
payload_out  in  MAX_PAYLOAD*8  read data from master, same packing
payload_length  out  LEN_N  LEN field; transfer is LEN+1 bytes
start_read  out  1  single-cycle pulse
start_write  out  1  single-cycle pulse
completed  in  1  master done pulse
timeout  in  1  master timeout pulse

Behaviour:
- Reset (rst_i low, async): state=CMD, all outputs 0, except rx_ready_o=1 once state is CMD after release; payload_in, transfer_address, payload_length cleared.
- Frame: CMD byte [7:6]=op (00 read, 01 write, 10 ping, 11 invalid), [LEN_N-1:0]=LEN; then ADDR_H, ADDR_L; write adds LEN+1 data bytes, byte 0 first.
- States: CMD -> ADDR_H -> ADDR_L -> (write: DATA) -> START -> WAIT -> STATUS -> (read: RDATA) -> CMD.
- Ping: CMD -> STATUS directly, status 0x00, no address bytes. Invalid op: CMD -> STATUS, status 0x80, no bus activity.
- rx_ready_o=1 only in CMD/ADDR_H/ADDR_L/DATA; 0 elsewhere (no bytes consumed during bus or response phase).
- DATA: byte counter 0..LEN; each accepted byte written to payload_in lane counter; at counter==LEN go to START.
- START: one cycle; start_read or start_write =1 exactly this cycle, address/payload/length stable from START until WAIT exits.
- WAIT: exit on completed or timeout in any cycle after START; timeout takes priority if both high -> status 0x01; else 0x00. Capture payload_out on the exit cycle.
- STATUS: tx_valid_o=1, tx_data_o=status, held until tx_ready_i. After accept: read with status 0x00 -> RDATA; otherwise -> CMD (no data on failed read).
- RDATA: emit LEN+1 captured bytes, byte 0 first, each held until accepted.
- RX timeout: idle counter resets on each accepted byte; in ADDR_H/ADDR_L/DATA reaching RX_TIMEOUT cycles discards frame -> CMD, no response, no start pulse. Counter inactive in CMD, START, WAIT, STATUS, RDATA.
- No bus timeout in bridge; relies on master's timeout. Reset mid-operation aborts everything; a start pulse must never be emitted after reset release without a fresh full frame.
- Latency: last frame byte accepted -> start pulse next cycle; completed -> tx_valid_o next cycle.

Test Plan:
- Read: rx 0x03,0x00,0x12; master completes with payload_out=0x..04030201 -> start_read one pulse, address 0x0012, length 3; tx 0x00,0x01,0x02,0x03,0x04.
- Write: rx 0x41,0xAB,0xCD,0x55,0xAA -> payload_in[15:0]=0xAA55, length 1, address 0xABCD, single start_write; tx 0x00 only.
- Timeout: read frame, master asserts timeout (and completed same cycle) -> tx 0x01 only, no data bytes.
- Ping/invalid: rx 0x80 -> tx 0x00; rx 0xC0 -> tx 0x80; no start pulses.
- Backpressure: tx_ready_i low 5 cycles during RDATA -> tx_data_o/tx_valid_o stable, no byte lost or duplicated; rx_ready_o stays 0.
- Abort: rx 0x41,0x00 then idle RX_TIMEOUT cycles -> back to CMD, no start; next valid ping answered 0x00. Reset asserted in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_packet_bridge.sv
// wb_packet_bridge: parses read/write/ping byte frames into wishbone_master packet commands
// and streams back a status byte plus read payload.
module wb_packet_bridge #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_PAYLOAD   = 8,
    parameter int LEN_N         = 3,
    parameter int RX_TIMEOUT    = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [DATA_WIDTH-1:0]             rx_data_i,
    input  logic                              rx_valid_i,
    output logic                              rx_ready_o,
    output logic [DATA_WIDTH-1:0]             tx_data_o,
    output logic                              tx_valid_o,
    input  logic                              tx_ready_i,
    output logic [ADDRESS_WIDTH-1:0]          transfer_address,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_in,
    input  logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_out,
    output logic [LEN_N-1:0]                  payload_length,
    output logic                              start_read,
    output logic                              start_write,
    input  logic                              completed,
    input  logic                              timeout
);
    localparam int PW = MAX_PAYLOAD * DATA_WIDTH;
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_START, S_WAIT, S_STATUS, S_RDATA
    } state_t;

    state_t                  state_q;
    logic                    live_q;
    logic [1:0]              op_q;
    logic [LEN_N-1:0]        len_q;
    logic [LEN_N-1:0]        cnt_q;
    logic [2*DATA_WIDTH-1:0] addr_q;
    logic [PW-1:0]           payload_q;
    logic [PW-1:0]           rdata_q;
    logic [DATA_WIDTH-1:0]   status_q;
    logic [TW-1:0]           idle_q;
    logic                    rx_phase, rx_fire, tx_fire, rx_to;

    // live_q keeps rx_ready_o low while reset is held even though state is CMD
    assign rx_phase         = state_q inside {S_CMD, S_ADDR_H, S_ADDR_L, S_DATA};
    assign rx_ready_o       = live_q & rx_phase;
    assign rx_fire          = rx_valid_i & rx_ready_o;
    assign tx_valid_o       = state_q inside {S_STATUS, S_RDATA};
    assign tx_fire          = tx_valid_o & tx_ready_i;
    assign tx_data_o        = state_q == S_STATUS ? status_q :
                              state_q == S_RDATA  ? rdata_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rx_to            = rx_phase && state_q != S_CMD && !rx_fire && idle_q == TW'(RX_TIMEOUT - 1);
    assign start_read       = state_q == S_START && !op_q[0];
    assign start_write      = state_q == S_START && op_q[0];
    assign transfer_address = addr_q[ADDRESS_WIDTH-1:0];
    assign payload_in       = payload_q;
    assign payload_length   = len_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_CMD;
            live_q    <= 1'b0;
            op_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            payload_q <= '0;
            rdata_q   <= '0;
            status_q  <= '0;
            idle_q    <= '0;
        end else begin
            live_q <= 1'b1;
            idle_q <= (rx_fire || !rx_phase || state_q == S_CMD) ? '0 : idle_q + 1'b1;
            if (rx_to) state_q <= S_CMD;
            else case (state_q)
                S_CMD: if (rx_fire) begin
                    op_q     <= rx_data_i[7:6];
                    len_q    <= rx_data_i[LEN_N-1:0];
                    cnt_q    <= '0;
                    // ping (10) answers 0x00, invalid (11) answers 0x80
                    status_q <= rx_data_i[7] ? {rx_data_i[6], {(DATA_WIDTH-1){1'b0}}} : '0;
                    state_q  <= rx_data_i[7] ? S_STATUS : S_ADDR_H;
                end
                S_ADDR_H: if (rx_fire) begin
                    addr_q[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_data_i;
                    state_q <= S_ADDR_L;
                end
                S_ADDR_L: if (rx_fire) begin
                    addr_q[DATA_WIDTH-1:0] <= rx_data_i;
                    state_q <= op_q[0] ? S_DATA : S_START;
                end
                S_DATA: if (rx_fire) begin
                    payload_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= rx_data_i;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == len_q) state_q <= S_START;
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: if (completed || timeout) begin
                    status_q <= {{(DATA_WIDTH-1){1'b0}}, timeout};
                    rdata_q  <= payload_out;
                    state_q  <= S_STATUS;
                end
                S_STATUS: if (tx_fire) begin
                    cnt_q   <= '0;
                    state_q <= (op_q == 2'b00 && status_q == '0) ? S_RDATA : S_CMD;
                end
                S_RDATA: if (tx_fire) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == len_q) state_q <= S_CMD;
                end
                default: state_q <= S_CMD;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_packet_bridge.sv
// tb_wb_packet_bridge: directed checks of framing, responses, backpressure, rx timeout and reset abort.
module tb_wb_packet_bridge;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic [15:0] transfer_address;
    logic [63:0] payload_in;
    logic [63:0] payload_out = '0;
    logic [2:0]  payload_length;
    logic        start_read, start_write;
    logic        completed = 1'b0;
    logic        timeout = 1'b0;

    int tests = 0;
    int fails = 0;
    int n_rd = 0;
    int n_wr = 0;
    logic [7:0] tx_q[$];

    wb_packet_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .transfer_address(transfer_address), .payload_in(payload_in), .payload_out(payload_out),
        .payload_length(payload_length), .start_read(start_read), .start_write(start_write),
        .completed(completed), .timeout(timeout)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (start_read) n_rd++;
        if (start_write) n_wr++;
        if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data_i = b;
        rx_valid_i = 1'b1;
        for (int k = 0; k < 20 && !rx_ready_o; k++) tick();
        check("rx_accept", 64'(rx_ready_o), 64'd1);
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic master(input logic [63:0] pl, input logic to);
        repeat (2) tick();
        payload_out = pl;
        completed = 1'b1;
        timeout = to;
        tick();
        completed = 1'b0;
        timeout = 1'b0;
        check("resp_latency", 64'(tx_valid_o), 64'd1);
        check("rx_blocked_resp", 64'(rx_ready_o), 64'd0);
    endtask

    task automatic drain(input string tag, input int n);
        for (int k = 0; k < 200 && tx_q.size() < n; k++) tick();
        repeat (3) tick();
        check(tag, 64'(tx_q.size()), 64'(n));
    endtask

    logic [7:0] exp_rd[5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] held;
    logic       stable;

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_rx_ready", 64'(rx_ready_o), 64'd0);
        check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
        check("rst_starts", 64'({start_read, start_write}), 64'd0);
        check("rst_payload_in", payload_in, 64'd0);
        check("rst_addr_len", 64'({transfer_address, payload_length}), 64'd0);
        rst_i = 1'b1;
        tick();
        check("post_rst_rx_ready", 64'(rx_ready_o), 64'd1);

        // read of 4 bytes at 0x0012
        tx_q.delete();
        send(8'h03); send(8'h00); send(8'h12);
        check("rd_start_pulse", 64'({start_read, start_write}), 64'h2);
        check("rd_addr", 64'(transfer_address), 64'h0012);
        check("rd_len", 64'(payload_length), 64'd3);
        tick();
        check("rd_start_single", 64'(start_read), 64'd0);
        master(64'hFFFF_FFFF_0403_0201, 1'b0);
        drain("rd_count", 5);
        for (int i = 0; i < 5; i++) if (i < tx_q.size()) check("rd_byte", 64'(tx_q[i]), 64'(exp_rd[i]));
        check("rd_pulses", 64'({n_rd[7:0], n_wr[7:0]}), 64'h0100);
        check("rd_back_cmd", 64'(rx_ready_o), 64'd1);

        // write of 2 bytes at 0xABCD
        tx_q.delete();
        send(8'h41); send(8'hAB); send(8'hCD); send(8'h55); send(8'hAA);
        check("wr_start_pulse", 64'({start_read, start_write}), 64'h1);
        check("wr_addr", 64'(transfer_address), 64'hABCD);
        check("wr_len", 64'(payload_length), 64'd1);
        check("wr_payload", 64'(payload_in[15:0]), 64'hAA55);
        master(64'd0, 1'b0);
        drain("wr_count", 1);
        if (tx_q.size() > 0) check("wr_status", 64'(tx_q[0]), 64'h00);
        check("wr_pulses", 64'({n_rd[7:0], n_wr[7:0]}), 64'h0101);

        // bus timeout with completed in the same cycle
        tx_q.delete();
        send(8'h03); send(8'h00); send(8'h12);
        master(64'h0403_0201, 1'b1);
        drain("to_count", 1);
        if (tx_q.size() > 0) check("to_status", 64'(tx_q[0]), 64'h01);

        // ping and invalid op
        tx_q.delete();
        send(8'h80);
        drain("ping_count", 1);
        if (tx_q.size() > 0) check("ping_status", 64'(tx_q[0]), 64'h00);
        tx_q.delete();
        send(8'hC0);
        drain("inv_count", 1);
        if (tx_q.size() > 0) check("inv_status", 64'(tx_q[0]), 64'h80);
        check("ping_inv_pulses", 64'({n_rd[7:0], n_wr[7:0]}), 64'h0201);

        // backpressure during RDATA
        tx_q.delete();
        send(8'h03); send(8'h00); send(8'h12);
        master(64'h0403_0201, 1'b0);
        for (int k = 0; k < 50 && tx_q.size() < 2; k++) tick();
        tx_ready_i = 1'b0;
        held = tx_data_o;
        check("bp_held_byte", 64'(held), 64'h02);
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!tx_valid_o || tx_data_o !== held || rx_ready_o) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        tx_ready_i = 1'b1;
        drain("bp_count", 5);
        for (int i = 0; i < 5; i++) if (i < tx_q.size()) check("bp_byte", 64'(tx_q[i]), 64'(exp_rd[i]));

        // partial frame abandoned by rx idle timeout
        tx_q.delete();
        send(8'h41); send(8'h00);
        repeat (1030) tick();
        check("abort_quiet", 64'({n_wr[7:0], 8'(tx_q.size())}), 64'h0100);
        send(8'h80);
        drain("abort_ping_count", 1);
        if (tx_q.size() > 0) check("abort_ping", 64'(tx_q[0]), 64'h00);

        // reset while waiting for the master
        tx_q.delete();
        send(8'h03); send(8'h00); send(8'h12);
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        check("wrst_rx_tx", 64'({rx_ready_o, tx_valid_o}), 64'd0);
        check("wrst_starts", 64'({start_read, start_write}), 64'd0);
        check("wrst_addr_len", 64'({transfer_address, payload_length}), 64'd0);
        tick();
        rst_i = 1'b1;
        tick();
        completed = 1'b1;
        tick();
        completed = 1'b0;
        repeat (20) tick();
        check("wrst_no_activity", 64'({n_rd[7:0], 8'(tx_q.size())}), 64'h0400);
        send(8'h80);
        drain("wrst_ping_count", 1);
        if (tx_q.size() > 0) check("wrst_ping", 64'(tx_q[0]), 64'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
